varlat_bank_adapter: RTL and testbench

Bank-side adapter between the variable-latency in-order interconnect and one fixed-latency SRAM macro. It converts the SRAM's fixed read latency into the interconnect's `rvalid`/`rready` response handshake. Responses are buffered in a small FIFO, and requests are throttled with a credit counter so no response is ever dropped under back-pressure. One instance sits behind each interconnect output port.

---
 rtl/memory_island_pkg.sv | 32 +++
 rtl/fifo_v3.sv | 81 ++++++++
 rtl/varlat_bank_adapter.sv | 127 ++++++++++++
 tb/tb_varlat_bank_adapter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_island_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_island_pkg
// Description : Shared types and helpers for the memory-island bank adapters.
//               Holds the bank request struct, the response payload type and
//               the credit-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_island_pkg;

    localparam int c_ADDR_MEM_WIDTH = 12;
    localparam int c_DATA_WIDTH     = 32;
    localparam int c_BE_WIDTH       = c_DATA_WIDTH / 8;

    // Request as seen at the bank port.
    typedef struct packed {
        logic                        we;
        logic [c_BE_WIDTH-1:0]       be;
        logic [c_ADDR_MEM_WIDTH-1:0] addr;
        logic [c_DATA_WIDTH-1:0]     wdata;
    } bank_req_t;

    // Response payload carried by the response FIFO.
    typedef logic [c_DATA_WIDTH-1:0] bank_rdata_t;

    // Bits needed to count 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_v3.sv
`default_nettype none
// ============================================================================
// Module      : fifo_v3
// Description : Small synchronous FIFO with optional fall-through. In
//               fall-through mode a push into an empty FIFO is visible on
//               data_o in the same cycle; a push and pop in that cycle bypass
//               the storage entirely.
// Ports       : clk_i, rst_ni (async, active-low), flush_i (sync clear),
//               full_o, empty_o, data_i/push_i (write side),
//               data_o/pop_i (read side).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_v3 #(
    parameter bit FALL_THROUGH = 1'b0,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_CNT_W-1:0]    r_cnt;

    logic w_stored_empty;
    logic w_bypass;
    logic w_write;
    logic w_read;

    assign w_stored_empty = (r_cnt == '0);
    assign w_bypass       = FALL_THROUGH & w_stored_empty & push_i;
    assign empty_o        = w_stored_empty & ~w_bypass;
    assign full_o         = (r_cnt == c_CNT_W'(DEPTH));
    assign data_o         = w_bypass ? data_i : r_mem[r_rd_ptr];

    // A bypassed beat that is popped in the same cycle never touches storage.
    assign w_write = push_i & ~full_o & ~(w_bypass & pop_i);
    assign w_read  = pop_i & ~w_stored_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_write) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_read) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            if (w_write & ~w_read) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else if (~w_write & w_read) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/varlat_bank_adapter.sv
`default_nettype none
// ============================================================================
// Module      : varlat_bank_adapter
// Description : Adapts a fixed-latency SRAM macro to the variable-latency
//               in-order interconnect. Response-producing requests consume a
//               credit; a tag pipeline matching the SRAM latency marks which
//               read-data beats are pushed into a fall-through response FIFO.
//               Credits equal FIFO depth, so a push never finds it full.
// Ports       : clk_i, rst_i (async, active-high)
//               req_i/gnt_o, add_i, we_i, wdata_i, be_i  - request side
//               rvalid_o/rready_i, rdata_o              - response side
//               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
//               mem_rdata_i                             - SRAM side
// Revision    : 1.0 - initial release
// ============================================================================
import memory_island_pkg::*;

module varlat_bank_adapter #(
    parameter int AddrMemWidth = 12,
    parameter int DataWidth    = 32,
    parameter int BeWidth      = DataWidth / 8,
    parameter int SramLatency  = 1,
    parameter int RespDepth    = 2,
    parameter bit WriteRespOn  = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [AddrMemWidth-1:0] add_i,
    input  logic                    we_i,
    input  logic [DataWidth-1:0]    wdata_i,
    input  logic [BeWidth-1:0]      be_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [AddrMemWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    output logic [BeWidth-1:0]      mem_be_o,
    input  logic [DataWidth-1:0]    mem_rdata_i
);

    localparam int c_CNT_W = cnt_width(RespDepth);

    logic [c_CNT_W-1:0]     r_credit;
    logic [SramLatency-1:0] r_tag;

    logic w_resp_req;
    logic w_take;
    logic w_pop;
    logic w_push;
    logic w_full;
    logic w_empty;

    // Writes need no credit when they produce no response beat. The grant
    // looks only at the credit register, so a pop frees a credit next cycle.
    assign w_resp_req = ~we_i | WriteRespOn;
    assign gnt_o      = req_i & ~rst_i & ((r_credit != '0) | (we_i & ~WriteRespOn));
    assign mem_req_o  = req_i & gnt_o;

    assign mem_we_o    = we_i;
    assign mem_addr_o  = add_i;
    assign mem_wdata_o = wdata_i;
    assign mem_be_o    = be_i;

    assign w_take   = mem_req_o & w_resp_req;
    assign w_pop    = rvalid_o & rready_i;
    assign rvalid_o = ~w_empty;
    assign w_push   = r_tag[SramLatency-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_credit <= c_CNT_W'(RespDepth);
        end else if (w_take & ~w_pop) begin
            r_credit <= r_credit - c_CNT_W'(1);
        end else if (~w_take & w_pop) begin
            r_credit <= r_credit + c_CNT_W'(1);
        end
    end

    // Tag pipeline: bit i marks that the SRAM beat arriving i+1 cycles after
    // acceptance belongs to a response-producing request.
    if (SramLatency == 1) begin : g_tag_single
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_tag <= '0;
            end else begin
                r_tag <= w_take;
            end
        end
    end else begin : g_tag_shift
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_tag <= '0;
            end else begin
                r_tag <= {r_tag[SramLatency-2:0], w_take};
            end
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b1),
        .DATA_WIDTH   (DataWidth),
        .DEPTH        (RespDepth)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (~rst_i),
        .flush_i (1'b0),
        .full_o  (w_full),
        .empty_o (w_empty),
        .data_i  (mem_rdata_i),
        .push_i  (w_push),
        .data_o  (rdata_o),
        .pop_i   (w_pop)
    );

`ifndef SYNTHESIS
    a_credit_range : assert property (@(posedge clk_i) disable iff (rst_i)
        (r_credit <= c_CNT_W'(RespDepth)) && !(w_take && !w_pop && (r_credit == '0)));
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && w_full));
`endif

endmodule
`default_nettype wire

// File: tb/tb_varlat_bank_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_varlat_bank_adapter
// Description : Directed self-checking bench. Instance A: latency 1, depth 2,
//               write responses on. Instance B: latency 2, depth 2, write
//               responses off. Each has a small behavioural SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_varlat_bank_adapter;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;

    logic        a_req, a_gnt, a_we, a_rvalid, a_rready;
    logic [11:0] a_addr, a_mem_addr;
    logic [31:0] a_wdata, a_rdata, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_be, a_mem_be;
    logic        a_mem_req, a_mem_we;

    logic        b_req, b_gnt, b_we, b_rvalid, b_rready;
    logic [11:0] b_addr, b_mem_addr;
    logic [31:0] b_wdata, b_rdata, b_mem_wdata, b_mem_rdata, b_stage;
    logic [3:0]  b_be, b_mem_be;
    logic        b_mem_req, b_mem_we;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic        mem_init = 1'b0;

    always #5 clk = ~clk;

    varlat_bank_adapter #(
        .AddrMemWidth(12), .DataWidth(32), .BeWidth(4),
        .SramLatency(1), .RespDepth(2), .WriteRespOn(1'b1)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(a_req), .gnt_o(a_gnt), .add_i(a_addr),
        .we_i(a_we), .wdata_i(a_wdata), .be_i(a_be), .rvalid_o(a_rvalid),
        .rready_i(a_rready), .rdata_o(a_rdata), .mem_req_o(a_mem_req),
        .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
        .mem_be_o(a_mem_be), .mem_rdata_i(a_mem_rdata)
    );

    varlat_bank_adapter #(
        .AddrMemWidth(12), .DataWidth(32), .BeWidth(4),
        .SramLatency(2), .RespDepth(2), .WriteRespOn(1'b0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(b_req), .gnt_o(b_gnt), .add_i(b_addr),
        .we_i(b_we), .wdata_i(b_wdata), .be_i(b_be), .rvalid_o(b_rvalid),
        .rready_i(b_rready), .rdata_o(b_rdata), .mem_req_o(b_mem_req),
        .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
        .mem_be_o(b_mem_be), .mem_rdata_i(b_mem_rdata)
    );

    // SRAM models: A answers one cycle after the request, B two cycles after.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 32'hA000_0000 | 32'(i);
                mem_b[i] <= 32'hC0DE_0000 | 32'(i);
            end
            mem_a[16] <= 32'hDEAD_BEEF;
            mem_init  <= 1'b1;
        end else begin
            if (a_mem_req) begin
                if (a_mem_we) begin
                    for (int k = 0; k < 4; k++) begin
                        if (a_mem_be[k]) mem_a[a_mem_addr[7:0]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
                    end
                end else begin
                    a_mem_rdata <= mem_a[a_mem_addr[7:0]];
                end
            end
            if (b_mem_req) begin
                if (b_mem_we) begin
                    for (int k = 0; k < 4; k++) begin
                        if (b_mem_be[k]) mem_b[b_mem_addr[7:0]][8*k +: 8] <= b_mem_wdata[8*k +: 8];
                    end
                end else begin
                    b_stage <= mem_b[b_mem_addr[7:0]];
                end
            end
            b_mem_rdata <= b_stage;
        end
    end

    task automatic test_reset();
        rst = 1'b1; a_req = 1'b1; b_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt_a: got %b want 0", a_gnt); end
        checks++; if (a_mem_req !== 1'b0) begin errors++; $display("FAIL rst_memreq_a: got %b want 0", a_mem_req); end
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid_a: got %b want 0", a_rvalid); end
        checks++; if (b_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt_b: got %b want 0", b_gnt); end
        checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid_b: got %b want 0", b_rvalid); end
        @(negedge clk); rst = 1'b0; a_req = 1'b0; b_req = 1'b0; #1;
        checks++; if (dut_a.r_credit !== 2'd2) begin errors++; $display("FAIL rst_credit_a: got %0d want 2", dut_a.r_credit); end
    endtask

    task automatic test_single_read();
        @(negedge clk); a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010; a_rready = 1'b1; #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", a_gnt); end
        checks++; if (a_mem_req !== 1'b1 || a_mem_addr !== 12'h010) begin errors++; $display("FAIL rd_memreq: got %b/%h want 1/010", a_mem_req, a_mem_addr); end
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_T: got %b want 0", a_rvalid); end
        @(negedge clk); a_req = 1'b0; #1;
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_resp: got %b/%h want 1/deadbeef", a_rvalid, a_rdata); end
        @(negedge clk); #1;
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_T2: got %b want 0", a_rvalid); end
        checks++; if (dut_a.r_credit !== 2'd2) begin errors++; $display("FAIL rd_credit: got %0d want 2", dut_a.r_credit); end
    endtask

    task automatic test_write_resp();
        @(negedge clk); a_req = 1'b1; a_we = 1'b1; a_addr = 12'h020; a_wdata = 32'h1111_2222; a_be = 4'hF; a_rready = 1'b1; #1;
        checks++; if (a_gnt !== 1'b1 || a_mem_we !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b/%b want 1/1", a_gnt, a_mem_we); end
        @(negedge clk); a_we = 1'b0; #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL wr_rd_gnt: got %b want 1", a_gnt); end
        checks++; if (a_rvalid !== 1'b1) begin errors++; $display("FAIL wr_resp: got %b want 1", a_rvalid); end
        @(negedge clk); a_req = 1'b0; #1;
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h1111_2222) begin errors++; $display("FAIL wr_rd_resp: got %b/%h want 1/11112222", a_rvalid, a_rdata); end
        @(negedge clk); #1;
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL wr_idle: got %b want 0", a_rvalid); end
    endtask

    task automatic test_simultaneous();
        @(negedge clk); a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010; a_rready = 1'b0; #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL sim_gnt0: got %b want 1", a_gnt); end
        @(negedge clk); a_addr = 12'h030; a_rready = 1'b1; #1;
        checks++; if (a_gnt !== 1'b1 || dut_a.r_credit !== 2'd1) begin errors++; $display("FAIL sim_gnt1: got %b/%0d want 1/1", a_gnt, dut_a.r_credit); end
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sim_resp0: got %b/%h want 1/deadbeef", a_rvalid, a_rdata); end
        @(negedge clk); a_req = 1'b0; #1;
        checks++; if (dut_a.r_credit !== 2'd1) begin errors++; $display("FAIL sim_credit: got %0d want 1", dut_a.r_credit); end
        checks++; if (dut_a.u_resp_fifo.r_cnt !== 2'd0) begin errors++; $display("FAIL sim_occ: got %0d want 0", dut_a.u_resp_fifo.r_cnt); end
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hA000_0030) begin errors++; $display("FAIL sim_resp1: got %b/%h want 1/a0000030", a_rvalid, a_rdata); end
        @(negedge clk); #1;
        checks++; if (a_rvalid !== 1'b0 || dut_a.r_credit !== 2'd2) begin errors++; $display("FAIL sim_end: got %b/%0d want 0/2", a_rvalid, dut_a.r_credit); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk); a_req = 1'b1; a_we = 1'b0; a_addr = 12'h001; a_rready = 1'b0;
        @(negedge clk); a_addr = 12'h002; #1;
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hA000_0001) begin errors++; $display("FAIL mf_pre: got %b/%h want 1/a0000001", a_rvalid, a_rdata); end
        @(negedge clk); a_addr = 12'h003; rst = 1'b1; #1;
        checks++; if (a_gnt !== 1'b0 || a_rvalid !== 1'b0) begin errors++; $display("FAIL mf_rst: got %b/%b want 0/0", a_gnt, a_rvalid); end
        checks++; if (dut_a.r_credit !== 2'd2) begin errors++; $display("FAIL mf_credit: got %0d want 2", dut_a.r_credit); end
        @(negedge clk); rst = 1'b0; a_addr = 12'h010; #1;
        checks++; if (a_gnt !== 1'b1 || a_rvalid !== 1'b0) begin errors++; $display("FAIL mf_post: got %b/%b want 1/0", a_gnt, a_rvalid); end
        @(negedge clk); a_req = 1'b0; a_rready = 1'b1; #1;
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL mf_resp: got %b/%h want 1/deadbeef", a_rvalid, a_rdata); end
        @(negedge clk); #1;
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL mf_idle: got %b want 0", a_rvalid); end
    endtask

    task automatic test_back_pressure();
        @(negedge clk); b_req = 1'b1; b_we = 1'b0; b_addr = 12'h001; b_rready = 1'b0; #1;
        checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL bp_gnt0: got %b want 1", b_gnt); end
        @(negedge clk); b_addr = 12'h002; #1;
        checks++; if (b_gnt !== 1'b1 || b_rvalid !== 1'b0) begin errors++; $display("FAIL bp_gnt1: got %b/%b want 1/0", b_gnt, b_rvalid); end
        @(negedge clk); b_addr = 12'h003; #1;
        checks++; if (b_gnt !== 1'b0) begin errors++; $display("FAIL bp_stop: got %b want 0", b_gnt); end
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hC0DE_0001) begin errors++; $display("FAIL bp_d0: got %b/%h want 1/c0de0001", b_rvalid, b_rdata); end
        @(negedge clk); b_rready = 1'b1; #1;
        checks++; if (b_gnt !== 1'b0) begin errors++; $display("FAIL bp_nocomb: got %b want 0", b_gnt); end
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hC0DE_0001) begin errors++; $display("FAIL bp_hold: got %b/%h want 1/c0de0001", b_rvalid, b_rdata); end
        @(negedge clk); #1;
        checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b want 1", b_gnt); end
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hC0DE_0002) begin errors++; $display("FAIL bp_d1: got %b/%h want 1/c0de0002", b_rvalid, b_rdata); end
        @(negedge clk); b_req = 1'b0; #1;
        checks++; if (b_rvalid !== 1'b0 || dut_b.r_credit !== 2'd1) begin errors++; $display("FAIL bp_gap: got %b/%0d want 0/1", b_rvalid, dut_b.r_credit); end
        @(negedge clk); #1;
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hC0DE_0003) begin errors++; $display("FAIL bp_d2: got %b/%h want 1/c0de0003", b_rvalid, b_rdata); end
        @(negedge clk); #1;
        checks++; if (b_rvalid !== 1'b0 || dut_b.r_credit !== 2'd2) begin errors++; $display("FAIL bp_end: got %b/%0d want 0/2", b_rvalid, dut_b.r_credit); end
    endtask

    task automatic test_write_noresp();
        @(negedge clk); b_req = 1'b1; b_we = 1'b1; b_addr = 12'h005; b_wdata = 32'hA5A5_A5A5; b_be = 4'b0011; b_rready = 1'b1; #1;
        checks++; if (b_gnt !== 1'b1 || b_mem_req !== 1'b1 || b_mem_we !== 1'b1) begin errors++; $display("FAIL wn_req: got %b/%b/%b want 1/1/1", b_gnt, b_mem_req, b_mem_we); end
        checks++; if (b_mem_addr !== 12'h005 || b_mem_wdata !== 32'hA5A5_A5A5 || b_mem_be !== 4'b0011) begin errors++; $display("FAIL wn_pass: got %h/%h/%b want 005/a5a5a5a5/0011", b_mem_addr, b_mem_wdata, b_mem_be); end
        @(negedge clk); b_req = 1'b0; #1;
        checks++; if (dut_b.r_credit !== 2'd2) begin errors++; $display("FAIL wn_credit: got %0d want 2", dut_b.r_credit); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL wn_norsp%0d: got %b want 0", i, b_rvalid); end
            @(negedge clk); #1;
        end
        b_rready = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 12'h005; #1;
        @(negedge clk); b_addr = 12'h006; #1;
        checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL wn_rd1: got %b want 1", b_gnt); end
        @(negedge clk); b_we = 1'b1; b_addr = 12'h007; b_wdata = 32'h1234_5678; b_be = 4'hF; #1;
        checks++; if (b_gnt !== 1'b1 || b_mem_we !== 1'b1 || dut_b.r_credit !== 2'd0) begin errors++; $display("FAIL wn_cr0: got %b/%b/%0d want 1/1/0", b_gnt, b_mem_we, dut_b.r_credit); end
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hC0DE_A5A5) begin errors++; $display("FAIL wn_rdback: got %b/%h want 1/c0dea5a5", b_rvalid, b_rdata); end
        @(negedge clk); b_req = 1'b0; b_rready = 1'b1; #1;
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hC0DE_A5A5) begin errors++; $display("FAIL wn_hold: got %b/%h want 1/c0dea5a5", b_rvalid, b_rdata); end
        @(negedge clk); #1;
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hC0DE_0006) begin errors++; $display("FAIL wn_rd2: got %b/%h want 1/c0de0006", b_rvalid, b_rdata); end
        @(negedge clk); #1;
        checks++; if (b_rvalid !== 1'b0 || dut_b.r_credit !== 2'd2) begin errors++; $display("FAIL wn_end: got %b/%0d want 0/2", b_rvalid, dut_b.r_credit); end
    endtask

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = 4'hF; a_rready = 1'b0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = 4'hF; b_rready = 1'b0;
        test_reset();
        test_single_read();
        test_write_resp();
        test_simultaneous();
        test_reset_midflight();
        test_back_pressure();
        test_write_noresp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
